pipelined_rca: RTL
==================

PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning total operand/sum width in bits.
REQ-002 SHALL have parameter SEG, default 16, meaning ripple segment width per pipeline stage.
REQ-003 SHALL derive localparam STAGES = WIDTH/SEG; WIDTH%SEG!=0 or SEG<1 SHALL be an elaboration error.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand set present on a, b, cIn, sub.
REQ-007 in_ready  output  1  stage 0 can accept; transfer when in_valid&&in_ready.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cIn  input  1  carry in (add mode only).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present on s, cOut, ovf.
REQ-012 out_ready  input  1  consumer accepts; transfer when out_valid&&out_ready.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 cOut  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add: {cOut,s} SHALL equal a + b + cIn, mod 2^(WIDTH+1).
REQ-017 Sub: SHALL compute a + ~b + 1; cIn ignored.
REQ-018 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-019 Stage k (0..STAGES-1) SHALL add segment k (bits k*SEG+SEG-1:k*SEG) using carry registered by stage k-1 (stage 0: cIn or 1 if sub).
REQ-020 Unprocessed upper operand segments SHALL travel with the transaction in stage registers; finished lower sum segments SHALL be carried forward likewise.
REQ-021 Each stage SHALL hold a valid bit; stage k advances when !valid[k+1] || ready[k+1]; last stage ready = out_ready.
REQ-022 in_ready SHALL be !valid[0] || ready[0] (combinational, bubble-collapsing).
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-024 While out_valid && !out_ready, s/cOut/ovf SHALL hold stable; no transaction lost or duplicated.
REQ-025 Transactions SHALL emerge in acceptance order.
REQ-026 sub SHALL be sampled per transaction; mixed add/sub back-to-back SHALL be correct.
REQ-027 STAGES=1 SHALL degenerate to one registered full-width adder with same handshake.

Reset
REQ-028 rst high SHALL clear all valid bits immediately: out_valid=0; in_ready=1 after deassertion.
REQ-029 rst SHALL zero all data registers: s=0, cOut=0, ovf=0.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; none emerges afterward.

Structure
REQ-031 Shared package SHALL hold default WIDTH/SEG constants and the STAGES derivation function.
REQ-032 One sub-module rca_seg (SEG-bit combinational ripple adder: a, b, cin -> s, cout, carry into MSB) SHALL be instantiated per stage via generate.
REQ-033 No other sub-modules; handshake and stage registers SHALL live in pipelined_rca.

Verification (WIDTH=64, SEG=16)
REQ-034 a=FFFF_FFFF_FFFF_FFFF, b=1, cIn=0, sub=0 -> after 4 cycles s=0, cOut=1, ovf=0 (carry ripples all stages).
REQ-035 a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> s=8000_0000_0000_0000, cOut=0, ovf=1; a=5, b=7, sub=1 -> s=FFFF_FFFF_FFFF_FFFE, cOut=0, ovf=0.
REQ-036 8 back-to-back inputs, out_ready=1 -> 8 results on consecutive cycles starting cycle 4, in order.
REQ-037 out_ready=0 for 6 cycles during stream -> in_ready drops once 4 stages full, outputs held stable, all results delivered in order once out_ready=1.
REQ-038 rst asserted with 3 transactions in flight -> out_valid=0 immediately; no stale result appears after release; next input returns correct result in 4 cycles.
REQ-039 Random a, b, cIn, sub with random in_valid/out_ready vs reference model -> zero mismatches over 10k transactions.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared constants and helpers for the segmented, pipelined ripple-carry adder.
// Default geometry plus the stage-count derivation used by the top level.
package pipelined_rca_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SEG_DEF   = 16;

  // Number of ripple segments (one per pipeline stage); 0 flags a bad SEG.
  function automatic int calc_stages(input int w, input int seg);
    return (seg < 1) ? 0 : w / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Purely combinational W-bit ripple-carry segment.
// Exposes the carry into its MSB so the last stage can form signed overflow.
module rca_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         cm_o
);

  logic [W:0] c;

  // Bit-serial ripple: each bit's carry feeds the next.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o  = c[W];
  assign cm_o = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined add/sub: one SEG-bit ripple segment per stage, valid/ready flow.
// Operands travel with the transaction; finished sum segments accumulate.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);
  localparam int SEG_NZ = (SEG < 1) ? 1 : SEG;

  if ((SEG < 1) || (WIDTH % SEG_NZ != 0)) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a positive multiple of SEG");
  end

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic             m_q [STAGES];
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Subtract is a + ~b + 1; invert once at the entry so stages are mode-free.
  assign bx = sub ? ~b : b;
  assign c0 = sub | cIn;

  // Backward ready chain: a stage may load when empty or its successor moves.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] sa, sb, ss, s_d;
    logic             sc, sv;
    logic [SEG-1:0]   seg_s;
    logic             seg_c, seg_m;

    if (k == 0) begin : g_src_in
      assign sa = a;
      assign sb = bx;
      assign ss = '0;
      assign sc = c0;
      assign sv = in_valid;
    end else begin : g_src_prev
      assign sa = a_q[k-1];
      assign sb = b_q[k-1];
      assign ss = s_q[k-1];
      assign sc = c_q[k-1];
      assign sv = v_q[k-1];
    end

    rca_seg #(.W(SEG)) u_seg (
      .a_i  (sa[k*SEG +: SEG]),
      .b_i  (sb[k*SEG +: SEG]),
      .c_i  (sc),
      .s_o  (seg_s),
      .c_o  (seg_c),
      .cm_o (seg_m)
    );

    // Merge this stage's segment into the partial sum carried forward.
    always_comb begin
      s_d                = ss;
      s_d[k*SEG +: SEG]  = seg_s;
    end

    // Stage register: capture on advance, hold while downstream is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end else if (rdy[k]) begin
        v_q[k] <= sv;
        if (sv) begin
          a_q[k] <= sa;
          b_q[k] <= sb;
          s_q[k] <= s_d;
          c_q[k] <= seg_c;
          m_q[k] <= seg_m;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cOut      = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ m_q[STAGES-1];

endmodule
